// File: rtl/ps2_receiver.sv
// ps2_receiver
//   Receives PS/2 style frames (start bit, DATA_W data bits LSB first,
//   optional parity bit, stop bit) sampled on falling edges of a filtered
//   SCL. Good frames go into a small receive FIFO. Dropped frames raise a
//   one-cycle error pulse.
//
// Ports
//   clk        : system clock, all logic on its rising edge
//   rst        : asynchronous active-low reset
//   SCL, SDA   : PS/2 clock and data lines, asynchronous, idle high
//   data_out   : FIFO head entry
//   data_valid : FIFO not empty
//   data_ready : consumer accepts data_out (pop when data_valid is also high)
//   parity_err : one-cycle pulse, frame dropped for bad parity
//   frame_err  : one-cycle pulse, frame dropped for bad stop bit or timeout
//   overflow   : one-cycle pulse, good frame dropped because FIFO is full
//   fifo_count : current FIFO occupancy
module ps2_receiver #(
  parameter int DATA_W      = 8,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_ODD  = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int FILTER      = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          SCL,
  input  logic                          SDA,
  output logic [DATA_W-1:0]             data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FILTER + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int BIT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronizers and filters reset to the idle-high level so that leaving
  // reset with both lines high never looks like an SCL falling edge.
  logic [1:0]        r_sclSync, r_sdaSync;
  logic              r_sclFilt, r_sdaFilt, r_sclFiltD;
  logic [FCNT_W-1:0] r_sclCnt, r_sdaCnt;
  logic              w_sample;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclSync  <= 2'b11;
      r_sdaSync  <= 2'b11;
      r_sclFilt  <= 1'b1;
      r_sdaFilt  <= 1'b1;
      r_sclFiltD <= 1'b1;
      r_sclCnt   <= '0;
      r_sdaCnt   <= '0;
    end else begin
      r_sclSync  <= {r_sclSync[0], SCL};
      r_sdaSync  <= {r_sdaSync[0], SDA};
      r_sclFiltD <= r_sclFilt;
      // The counter tracks how many consecutive samples disagree with the
      // filtered level; any agreeing sample restarts the count.
      if (r_sclSync[1] == r_sclFilt) begin
        r_sclCnt <= '0;
      end else if (r_sclCnt == FCNT_W'(FILTER - 1)) begin
        r_sclFilt <= r_sclSync[1];
        r_sclCnt  <= '0;
      end else begin
        r_sclCnt <= r_sclCnt + FCNT_W'(1);
      end
      if (r_sdaSync[1] == r_sdaFilt) begin
        r_sdaCnt <= '0;
      end else if (r_sdaCnt == FCNT_W'(FILTER - 1)) begin
        r_sdaFilt <= r_sdaSync[1];
        r_sdaCnt  <= '0;
      end else begin
        r_sdaCnt <= r_sdaCnt + FCNT_W'(1);
      end
    end
  end

  assign w_sample = r_sclFiltD & ~r_sclFilt;

  state_t            r_state, w_stateNext;
  logic [BIT_W-1:0]  r_bitCnt, w_bitCntNext;
  logic [DATA_W-1:0] r_shift, w_shiftNext;
  logic              r_parityOk, w_parityOkNext;
  logic [TO_W-1:0]   r_toCnt, w_toCntNext;
  logic              r_parityErr, r_frameErr, r_overflow;
  logic              w_push, w_parErr, w_frmErr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_parityOk  <= 1'b1;
      r_toCnt     <= '0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_bitCnt    <= w_bitCntNext;
      r_shift     <= w_shiftNext;
      r_parityOk  <= w_parityOkNext;
      r_toCnt     <= w_toCntNext;
      r_parityErr <= w_parErr;
      r_frameErr  <= w_frmErr;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_bitCntNext   = r_bitCnt;
    w_shiftNext    = r_shift;
    w_parityOkNext = r_parityOk;
    w_toCntNext    = '0;
    w_push         = 1'b0;
    w_parErr       = 1'b0;
    w_frmErr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sample && !r_sdaFilt) begin
          w_stateNext    = DATA;
          w_bitCntNext   = '0;
          w_parityOkNext = 1'b1;
        end
      end
      DATA: begin
        // Shifting in from the top leaves the first (LSB) bit at position 0
        // once all DATA_W bits have arrived.
        if (w_sample) begin
          w_shiftNext  = {r_sdaFilt, r_shift[DATA_W-1:1]};
          w_bitCntNext = r_bitCnt + BIT_W'(1);
          if (r_bitCnt == BIT_W'(DATA_W - 1)) begin
            w_stateNext = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (w_sample) begin
          w_parityOkNext = ((^r_shift) ^ r_sdaFilt) == 1'(PARITY_ODD);
          w_stateNext    = STOP;
        end
      end
      STOP: begin
        if (w_sample) begin
          w_stateNext = IDLE;
          if (!r_sdaFilt) begin
            w_frmErr = 1'b1;
          end else if (r_parityOk) begin
            w_push = 1'b1;
          end else begin
            w_parErr = 1'b1;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
    // Inactivity watchdog: counts only while a frame is in progress and
    // aborts it when no SCL falling edge arrives in time.
    if (r_state != IDLE && !w_sample) begin
      if (r_toCnt == TO_W'(TIMEOUT_CYC - 1)) begin
        w_stateNext = IDLE;
        w_frmErr    = 1'b1;
      end else begin
        w_toCntNext = r_toCnt + TO_W'(1);
      end
    end
  end

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr, r_rdPtr;
  logic [PTR_W:0]    r_count;
  logic              w_pop, w_full, w_wr, w_ovf;

  // A push into a full FIFO still succeeds if a pop happens in the same
  // cycle: the write lands in the slot being vacated.
  assign w_pop  = (r_count != '0) && data_ready;
  assign w_full = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovf  = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_ovf;
      if (w_wr) begin
        r_mem[r_wrPtr] <= r_shift;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

  assign data_out   = r_mem[r_rdPtr];
  assign data_valid = (r_count != '0);
  assign fifo_count = r_count;
  assign parity_err = r_parityErr;
  assign frame_err  = r_frameErr;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver
//   Directed frames driven onto SCL/SDA; a queue of expected received bytes
//   and expected error-pulse counts is checked against the receiver.
module tb_ps2_receiver;

  localparam int DATA_W      = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        SCL = 1'b1;
  logic        SDA = 1'b1;
  logic        data_ready = 1'b0;
  logic [7:0]  data_out;
  logic        data_valid, parity_err, frame_err, overflow;
  logic [2:0]  fifo_count;

  ps2_receiver #(
    .DATA_W(DATA_W), .PARITY_EN(1), .PARITY_ODD(1), .FIFO_DEPTH(FIFO_DEPTH),
    .FILTER(4), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .SCL(SCL), .SDA(SDA),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int         nCompared = 0;
  int         nMismatch = 0;
  logic [7:0] expQ[$];
  bit         settling = 1'b0;
  bit         inReset = 1'b1;
  int         parErrSeen = 0, frmErrSeen = 0, ovfSeen = 0, validCycles = 0;
  int         expParErr = 0, expFrmErr = 0, expOvf = 0;
  logic [7:0] lastPopped = 8'h00;
  logic       prevPar = 1'b0, prevFrm = 1'b0, prevOvf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the expected-byte queue, sampled on the
  // falling clock edge away from the DUT's active edge.
  always @(negedge clk) begin
    if (inReset) begin
      check("reset data_valid", data_valid, 0);
      check("reset data_out", data_out, 0);
      check("reset fifo_count", fifo_count, 0);
      check("reset pulses", {parity_err, frame_err, overflow}, 0);
    end else begin
      if (!settling) begin
        check("fifo_count", fifo_count, expQ.size());
        check("data_valid", data_valid, expQ.size() != 0);
      end
      if (data_valid) begin
        validCycles++;
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatch++;
          $display("[TB] FAIL unexpected data: got 0x%0h, expected no data at %0t", data_out, $time);
        end else begin
          check("data_out", data_out, expQ[0]);
          if (data_ready) begin
            lastPopped = data_out;
            void'(expQ.pop_front());
          end
        end
      end
      if (parity_err && prevPar) check("parity_err width", 2, 1);
      if (frame_err && prevFrm) check("frame_err width", 2, 1);
      if (overflow && prevOvf) check("overflow width", 2, 1);
      if (parity_err) parErrSeen++;
      if (frame_err) frmErrSeen++;
      if (overflow) ovfSeen++;
    end
    prevPar = parity_err;
    prevFrm = frame_err;
    prevOvf = overflow;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data set up, SCL low for 20 cycles, high for 15; an
  // optional one-cycle SCL glitch is placed in the high phase.
  task automatic driveBit(input logic b, input bit glitch);
    SDA = b;
    waitCycles(5);
    SCL = 1'b0;
    waitCycles(20);
    SCL = 1'b1;
    if (glitch) begin
      waitCycles(5);
      SCL = 1'b0;
      waitCycles(1);
      SCL = 1'b1;
      waitCycles(9);
    end else begin
      waitCycles(15);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit badPar, input bit badStop,
                               input int glitchBit);
    logic [10:0] fr;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    fr[9]   = (^d) ^ 1'b1 ^ badPar;
    fr[10]  = ~badStop;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        if (badStop) expFrmErr++;
        else if (badPar) expParErr++;
        else if (expQ.size() == FIFO_DEPTH) expOvf++;
        else expQ.push_back(d);
        settling = 1'b1;
      end
      driveBit(fr[i], i == glitchBit);
    end
    settling = 1'b0;
    SDA = 1'b1;
    waitCycles(10);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " parity_err count"}, parErrSeen, expParErr);
    check({tag, " frame_err count"}, frmErrSeen, expFrmErr);
    check({tag, " overflow count"}, ovfSeen, expOvf);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    waitCycles(10);
    rst = 1'b1;
    inReset = 1'b0;
    waitCycles(20);
    data_ready = 1'b1;

    validCycles = 0;
    applyStimulus(8'h1C, 1'b0, 1'b0, -1);
    waitCycles(10);
    checkOutput("good 1C");
    check("1C popped", lastPopped, 8'h1C);
    check("1C valid cycles", validCycles, 1);
    check("1C no parity_err", parErrSeen, 0);

    applyStimulus(8'h1C, 1'b1, 1'b0, -1);
    checkOutput("bad parity");
    check("bad parity pulse", parErrSeen, 1);
    check("bad parity count", fifo_count, 0);

    applyStimulus(8'hF0, 1'b0, 1'b1, -1);
    checkOutput("bad stop");
    check("bad stop pulse", frmErrSeen, 1);
    check("bad stop no parity_err", parErrSeen, 1);

    driveBit(1'b0, 1'b0);
    driveBit(1'b1, 1'b0);
    driveBit(1'b0, 1'b0);
    driveBit(1'b1, 1'b0);
    expFrmErr++;
    waitCycles(TIMEOUT_CYC + 100);
    checkOutput("timeout");
    check("timeout pulse", frmErrSeen, 2);
    applyStimulus(8'h55, 1'b0, 1'b0, -1);
    checkOutput("after timeout");
    check("55 popped", lastPopped, 8'h55);

    SDA = 1'b0;
    waitCycles(5);
    SCL = 1'b0;
    waitCycles(1);
    SCL = 1'b1;
    waitCycles(5);
    SDA = 1'b1;
    waitCycles(30);
    applyStimulus(8'hA3, 1'b0, 1'b0, 3);
    checkOutput("glitch");
    check("A3 popped", lastPopped, 8'hA3);

    data_ready = 1'b0;
    for (int k = 1; k <= 5; k++) applyStimulus(8'(k), 1'b0, 1'b0, -1);
    waitCycles(10);
    checkOutput("overflow");
    check("overflow pulse", ovfSeen, 1);
    check("full count", fifo_count, 4);
    data_ready = 1'b1;
    waitCycles(20);
    check("last drained", lastPopped, 8'h04);
    check("drained count", fifo_count, 0);

    driveBit(1'b0, 1'b0);
    driveBit(1'b0, 1'b0);
    driveBit(1'b0, 1'b0);
    driveBit(1'b1, 1'b0);
    driveBit(1'b1, 1'b0);
    SDA = 1'b1;
    rst = 1'b0;
    inReset = 1'b1;
    waitCycles(5);
    rst = 1'b1;
    inReset = 1'b0;
    waitCycles(100);
    checkOutput("mid-frame reset");
    check("reset count", fifo_count, 0);
    applyStimulus(8'h3C, 1'b0, 1'b0, -1);
    checkOutput("after reset");
    check("3C popped", lastPopped, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, range 5..9.
REQ-002 Parameter PARITY_EN, default 1: 1 means a parity bit follows the data; 0 means no parity bit.
REQ-003 Parameter PARITY_ODD, default 1: 1 selects odd parity, 0 selects even.
REQ-004 Parameter FIFO_DEPTH, default 4: receive FIFO entries, a power of 2, at least 2.
REQ-005 Parameter FILTER, default 4: consecutive equal samples needed to accept an SCL/SDA level change.
REQ-006 Parameter TIMEOUT_CYC, default 5000: clk cycles without an SCL falling edge before a frame is aborted.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 SCL  in  1  PS/2 clock line, asynchronous to clk, idle high.
REQ-010 SDA  in  1  PS/2 data line, asynchronous to clk, idle high.
REQ-011 data_out  out  DATA_W  FIFO head entry.
REQ-012 data_valid  out  1  FIFO not empty.
REQ-013 data_ready  in  1  consumer accepts data_out.
REQ-014 parity_err  out  1  one-cycle pulse when a frame is dropped for bad parity.
REQ-015 frame_err  out  1  one-cycle pulse when a frame is dropped for a bad stop bit or a timeout.
REQ-016 overflow  out  1  one-cycle pulse when a good frame is dropped because the FIFO is full.
REQ-017 fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 SCL and SDA shall each pass through a 2-flop synchronizer, then a glitch filter whose output changes only after FILTER consecutive equal synchronized samples.
REQ-019 A sample event is a 1-to-0 transition of filtered SCL; filtered SDA is captured in that cycle.
REQ-020 The FSM shall have states IDLE, DATA, PARITY and STOP.
REQ-021 IDLE: a sample with SDA=0 (start bit) goes to DATA with bit_cnt=0; a sample with SDA=1 is ignored.
REQ-022 DATA: each sample writes bit bit_cnt (LSB first) and increments bit_cnt; after sample DATA_W-1 the FSM goes to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-023 PARITY: parity is good when the XOR of the data bits and the parity bit equals PARITY_ODD; the result is latched and the FSM goes to STOP.
REQ-024 STOP, SDA=1, parity good (or PARITY_EN=0): the frame is pushed to the FIFO.
REQ-025 STOP, SDA=1, parity bad: the frame is discarded and parity_err pulses.
REQ-026 STOP, SDA=0: the frame is discarded and frame_err pulses; parity_err does not pulse.
REQ-027 Every STOP outcome returns the FSM to IDLE.
REQ-028 A push shall be registered so that data_valid, data_out and fifo_count update 1 clk after the stop-bit sample cycle.
REQ-029 Timeout: outside IDLE, a counter cleared on each sample event reaching TIMEOUT_CYC forces IDLE, discards the partial frame and pulses frame_err; the counter is held at 0 in IDLE.
REQ-030 FIFO pop occurs when data_valid=1 and data_ready=1; data_out shall hold stable while data_valid=1 and data_ready=0.
REQ-031 Push when full with no pop: the frame is dropped, overflow pulses, and FIFO contents are unchanged.
REQ-032 Push when full with a simultaneous pop: both complete, no overflow, and fifo_count is unchanged.
REQ-033 Push when empty: data_valid is 0 in that cycle; there is no combinational bypass.
REQ-034 Pop when empty has no effect; fifo_count never underflows.
REQ-035 Read and write pointers shall wrap modulo FIFO_DEPTH.

Reset
REQ-036 While rst=0: FSM is IDLE, bit_cnt=0, timeout counter=0, FIFO empty, data_valid=0, data_out=0, fifo_count=0, parity_err=frame_err=overflow=0.
REQ-037 While rst=0: synchronizer and filter flops preset to 1, so releasing reset with lines high produces no sample event.
REQ-038 Reset asserted mid-frame discards the partial frame without any error pulse.

Verification
REQ-039 Frame 0x1C, odd parity bit 0, stop 1, data_ready=1 -> data_out=0x1C, data_valid high for 1 cycle, no error pulses.
REQ-040 Frame 0x1C with parity bit 1 -> parity_err 1-cycle pulse, fifo_count stays 0.
REQ-041 Frame 0xF0 with stop bit 0 -> frame_err pulse, no push.
REQ-042 Start plus 3 data bits, then SCL held high for TIMEOUT_CYC cycles -> frame_err pulse, FSM in IDLE; next full frame 0x55 is received correctly.
REQ-043 Five frames 0x01..0x05 with data_ready=0 and FIFO_DEPTH=4 -> fifo_count=4, overflow pulse on the fifth; pops return 0x01..0x04 in order.
REQ-044 1-cycle SCL glitch (< FILTER) during IDLE and DATA -> no sample event; rst pulsed after bit 4 -> no push, no error pulse, fifo_count=0.
